// File: rtl/wb_buffer_if.sv
// Bus bundle for the write-back buffer: cache eviction channel, cache fill
// channel and the single memory port.
interface wb_buffer_if #(
    parameter int ADDR_W = 27,
    parameter int LINE_W = 256
) ();
    logic              evict_valid;
    logic              evict_ready;
    logic [ADDR_W-1:0] evict_addr;
    logic [LINE_W-1:0] evict_data;
    logic              fill_valid;
    logic              fill_ready;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_rvalid;
    logic [LINE_W-1:0] fill_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;

    // The buffer itself: serves the cache, drives the memory port.
    modport slave (
        input  evict_valid, evict_addr, evict_data, fill_valid, fill_addr,
               mem_ack, mem_rdata,
        output evict_ready, fill_ready, fill_rvalid, fill_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    // The surrounding cache and memory.
    modport master (
        output evict_valid, evict_addr, evict_data, fill_valid, fill_addr,
               mem_ack, mem_rdata,
        input  evict_ready, fill_ready, fill_rvalid, fill_rdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/wb_buffer.sv
// Write-back buffer: queues dirty lines evicted by the cache, drains them to
// memory in the background and serves line fills from buffered data first.
//
// state | meaning
// IDLE  | no memory transaction; accepts fills, chooses fill or drain
// RD    | fill miss in flight on the memory port
// WR    | head entry being written to memory
module wb_buffer #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state, state_nxt;
    logic [DEPTH-1:0]  ent_valid;
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [LINE_W-1:0] ent_data [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;

    logic              evict_acc, fill_acc, start_wr, head_busy, push, pop;
    logic              ev_hit, fl_hit, fwd_hit, ev_same;
    logic [PTR_W-1:0]  ev_idx, fl_idx;
    logic [LINE_W-1:0] fwd_data;
    logic              fill_ready_c;

    logic              fill_rvalid_q;
    logic [LINE_W-1:0] fill_rdata_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;

    assign bus.evict_ready = (count < CNT_W'(DEPTH));
    assign bus.fill_ready  = fill_ready_c;
    assign bus.fill_rvalid = fill_rvalid_q;
    assign bus.fill_rdata  = fill_rdata_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;

    assign evict_acc = bus.evict_valid && bus.evict_ready;
    assign fill_acc  = bus.fill_valid && (state == IDLE);
    assign start_wr  = (state == IDLE) && !fill_acc && (count != '0);
    // The head is protected from in-place overwrite on the very edge its
    // drain is launched too, otherwise the new data would be popped unwritten.
    assign head_busy = (state == WR) || start_wr;
    assign pop       = (state == WR) && bus.mem_ack;
    assign push      = evict_acc && !ev_hit;
    assign ev_same   = evict_acc && (bus.evict_addr == bus.fill_addr);
    assign fwd_hit   = ev_same || fl_hit;
    assign fwd_data  = ev_same ? bus.evict_data : ent_data[fl_idx];

    // Address match of the incoming eviction and fill against buffered entries.
    always_comb begin
        ev_hit = 1'b0;
        ev_idx = '0;
        fl_hit = 1'b0;
        fl_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == bus.evict_addr) &&
                !(head_busy && (PTR_W'(i) == head))) begin
                ev_hit = 1'b1;
                ev_idx = PTR_W'(i);
            end
            if (ent_valid[i] && (ent_addr[i] == bus.fill_addr)) begin
                fl_hit = 1'b1;
                fl_idx = PTR_W'(i);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state selection; fills take priority over drains.
    always_comb begin
        state_nxt    = state;
        fill_ready_c = 1'b0;
        case (state)
            IDLE: begin
                fill_ready_c = 1'b1;
                if (fill_acc && !fwd_hit) state_nxt = RD;
                else if (start_wr)        state_nxt = WR;
            end
            RD:      if (bus.mem_ack) state_nxt = IDLE;
            WR:      if (bus.mem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FIFO bookkeeping: valid bits, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Line storage: in-place update on a hit, otherwise write at tail.
    always_ff @(posedge clk) begin
        if (evict_acc) begin
            if (ev_hit) begin
                ent_data[ev_idx] <= bus.evict_data;
            end else begin
                ent_addr[tail] <= bus.evict_addr;
                ent_data[tail] <= bus.evict_data;
            end
        end
    end

    // Registered fill response and memory port, held stable while mem_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_rvalid_q <= 1'b0;
            fill_rdata_q  <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            fill_rvalid_q <= 1'b0;
            if (fill_acc && fwd_hit) begin
                fill_rvalid_q <= 1'b1;
                fill_rdata_q  <= fwd_data;
            end
            if ((state == RD) && bus.mem_ack) begin
                fill_rvalid_q <= 1'b1;
                fill_rdata_q  <= bus.mem_rdata;
            end
            if (fill_acc && !fwd_hit) begin
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_addr_q <= bus.fill_addr;
            end else if (start_wr) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= ent_addr[head];
                mem_wdata_q <= ent_data[head];
            end else if ((state != IDLE) && bus.mem_ack) begin
                mem_req_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_buffer.sv
// Randomized bench for wb_buffer: a line-level reference model (queue of
// buffered lines plus a memory image) predicts fill data and drain writes,
// and a monitor compares them as the DUT presents them.
module tb_wb_buffer;
    localparam int DEPTH  = 4;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 27;

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef struct {
        addr_t a;
        line_t d;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    wb_buffer_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    wb_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    ent_t  mbuf[$];
    line_t model_mem[addr_t];
    line_t env_mem[addr_t];
    line_t fill_q[$];
    ent_t  wr_q[$];
    bit    busy = 0;
    bit    busy_wr = 0;
    addr_t rd_addr = '0;
    int    ack_delay = 0;
    int    max_delay = 3;
    ent_t  mon_e;
    addr_t pool[6] = '{27'h0000010, 27'h0000020, 27'h0000005, 27'h0000006,
                       27'h7FFFFFF, 27'h1234567};

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_line(string name, line_t act, line_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic line_t mem_init(addr_t a);
        line_t l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = {5'(i), a} ^ 32'hC3A5_5A3C;
        return l;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // One cycle of cache stimulus, memory responder and model update, run
    // on the falling edge; everything decided here takes effect next rising edge.
    task automatic step(bit en_ev, bit en_fill);
        bit    ev_acc, fill_acc, hit;
        line_t exp;
        @(negedge clk);
        if (bus.mem_ack) begin
            if (busy_wr) begin
                model_mem[mbuf[0].a] = mbuf[0].d;
                void'(mbuf.pop_front());
                env_mem[bus.mem_addr] = bus.mem_wdata;
            end
            busy    = 0;
            busy_wr = 0;
        end
        bus.mem_ack = 1'b0;
        check32("fill_ready", 32'(bus.fill_ready), 32'(!busy));
        check32("evict_ready", 32'(bus.evict_ready), 32'(mbuf.size() < DEPTH));
        check32("mem_req", 32'(bus.mem_req), 32'(busy));
        if (busy && bus.mem_req) begin
            if (ack_delay == 0) begin
                check32("mem_we", 32'(bus.mem_we), 32'(busy_wr));
                if (!busy_wr) check32("mem_addr_rd", 32'(bus.mem_addr), 32'(rd_addr));
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr]
                                                             : mem_init(bus.mem_addr);
            end else begin
                ack_delay--;
            end
        end
        bus.evict_valid = en_ev && ($urandom_range(0, 99) < 50);
        bus.evict_addr  = pool[$urandom_range(0, 5)];
        bus.evict_data  = rand_line();
        if (busy && !busy_wr && bus.evict_addr == rd_addr) bus.evict_valid = 1'b0;
        bus.fill_valid  = en_fill && ($urandom_range(0, 99) < 30);
        bus.fill_addr   = pool[$urandom_range(0, 5)];
        ev_acc   = bus.evict_valid && (mbuf.size() < DEPTH);
        fill_acc = bus.fill_valid && !busy;
        if (fill_acc) begin
            hit = 0;
            exp = '0;
            if (ev_acc && bus.evict_addr == bus.fill_addr) begin
                hit = 1;
                exp = bus.evict_data;
            end else begin
                foreach (mbuf[i]) if (mbuf[i].a == bus.fill_addr) begin
                    hit = 1;
                    exp = mbuf[i].d;
                end
            end
            if (!hit) begin
                busy      = 1;
                busy_wr   = 0;
                rd_addr   = bus.fill_addr;
                ack_delay = $urandom_range(0, max_delay);
                exp = model_mem.exists(rd_addr) ? model_mem[rd_addr] : mem_init(rd_addr);
            end
            fill_q.push_back(exp);
        end else if (!busy && mbuf.size() > 0) begin
            busy      = 1;
            busy_wr   = 1;
            ack_delay = $urandom_range(0, max_delay);
            wr_q.push_back(mbuf[0]);
        end
        if (ev_acc) begin
            hit = 0;
            for (int i = (busy_wr ? 1 : 0); i < mbuf.size(); i++) begin
                if (mbuf[i].a == bus.evict_addr) begin
                    mbuf[i].d = bus.evict_data;
                    hit = 1;
                end
            end
            if (!hit) mbuf.push_back('{bus.evict_addr, bus.evict_data});
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (mbuf.size() > 0 || busy); k++) step(0, 0);
        check32("drain_done", 32'(mbuf.size() == 0 && !busy), 32'd1);
    endtask

    // Scoreboard monitor: compares fill responses and memory writes.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            if (bus.fill_rvalid) begin
                if (fill_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL fill_rvalid: got pulse expected none");
                end else begin
                    check_line("fill_rdata", bus.fill_rdata, fill_q.pop_front());
                end
            end
            if (bus.mem_ack && bus.mem_we) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL mem_write: got write to %0h expected none", bus.mem_addr);
                end else begin
                    mon_e = wr_q.pop_front();
                    check32("mem_addr_wr", 32'(bus.mem_addr), 32'(mon_e.a));
                    check_line("mem_wdata", bus.mem_wdata, mon_e.d);
                end
            end
        end
    end

    initial begin
        bus.evict_valid = 1'b0;
        bus.evict_addr  = '0;
        bus.evict_data  = '0;
        bus.fill_valid  = 1'b0;
        bus.fill_addr   = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        #12;
        check32("rst_evict_ready", 32'(bus.evict_ready), 32'd1);
        check32("rst_fill_ready", 32'(bus.fill_ready), 32'd1);
        check32("rst_fill_rvalid", 32'(bus.fill_rvalid), 32'd0);
        check_line("rst_fill_rdata", bus.fill_rdata, '0);
        check32("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check32("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check32("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_line("rst_mem_wdata", bus.mem_wdata, '0);
        @(negedge clk);
        rst_n = 1'b1;

        repeat (400) step(1, 1);
        max_delay = 12;
        repeat (150) step(1, 0);
        max_delay = 3;
        drain();

        // Reset in the middle of a memory read: nothing may come back.
        @(negedge clk);
        bus.evict_valid = 1'b0;
        bus.fill_valid  = 1'b1;
        bus.fill_addr   = 27'h0000020;
        @(negedge clk);
        bus.fill_valid = 1'b0;
        check32("rd_mem_req", 32'(bus.mem_req), 32'd1);
        check32("rd_mem_we", 32'(bus.mem_we), 32'd0);
        check32("rd_fill_ready", 32'(bus.fill_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check32("midrst_mem_req", 32'(bus.mem_req), 32'd0);
        check32("midrst_evict_ready", 32'(bus.evict_ready), 32'd1);
        check32("midrst_fill_ready", 32'(bus.fill_ready), 32'd1);
        mbuf.delete();
        fill_q.delete();
        wr_q.delete();
        busy    = 0;
        busy_wr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check32("postrst_fill_rvalid", 32'(bus.fill_rvalid), 32'd0);
            check32("postrst_mem_req", 32'(bus.mem_req), 32'd0);
        end

        repeat (400) step(1, 1);
        drain();
        repeat (3) @(negedge clk);
        check32("fill_q_empty", 32'(fill_q.size()), 32'd0);
        check32("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_buffer.md
# wb_buffer

Write-back buffer between the data cache and the block-wide data memory. It accepts dirty 256-bit lines evicted by the cache, queues them, and drains them to memory in the background. Line fills from the cache pass through the buffer, which supplies buffered data directly, so a fill never returns stale memory contents. The block owns the only memory port and keeps at most one memory transaction outstanding.

## Interface
- DEPTH, 4, number of line entries (power of two, ≥2)
- LINE_W, 256, line width in bits (`BLOCK_SIZE`)
- ADDR_W, 27, line address width (word address bits [31:5])
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- evict_valid  in  1  cache presents a dirty line
- evict_ready  out  1  buffer accepts the line this cycle
- evict_addr  in  ADDR_W  line address of the evicted line
- evict_data  in  LINE_W  evicted line contents
- fill_valid  in  1  cache requests a line
- fill_ready  out  1  request accepted this cycle
- fill_addr  in  ADDR_W  requested line address
- fill_rvalid  out  1  one-cycle pulse, fill_rdata valid
- fill_rdata  out  LINE_W  returned line
- mem_req  out  1  memory transaction request, held until mem_ack
- mem_we  out  1  1 = write (drain), 0 = read (fill)
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  LINE_W  drain data
- mem_ack  in  1  one-cycle completion; mem_rdata valid on that cycle for reads
- mem_rdata  in  LINE_W  memory read data

## Operation
- Storage: circular FIFO of DEPTH entries {valid, addr, data}, head/tail pointers, count 0..DEPTH.
- Eviction: accepted when evict_valid && evict_ready; evict_ready = (count < DEPTH). If evict_addr matches a valid entry that is not the in-flight head, that entry's data is overwritten in place (count unchanged). Otherwise a new entry is pushed at tail.
- FSM states: IDLE, RD, WR.
- IDLE: fill_ready = 1. Fill accepted:
  - address matches an entry (or a same-cycle accepted eviction) -> forward data from the newest match (same-cycle eviction is newest); fill_rvalid next cycle; stay IDLE; no memory access.
  - no match -> latch address, go RD.
  - no fill but count > 0 -> go WR, head entry drives mem_addr/mem_wdata.
- Fill has priority over drain in IDLE.
- RD: mem_req = 1, mem_we = 0; on mem_ack, fill_rdata <= mem_rdata, fill_rvalid pulses next cycle, go IDLE.
- WR: mem_req = 1, mem_we = 1; on mem_ack, pop head (count-1), go IDLE. An eviction to the head address during WR pushes a new entry; it drains later, so memory ends with the newer data.
- Simultaneous pop and push: both occur, count unchanged; a push into a full FIFO is never possible (evict_ready low).
- fill_ready = 0 in RD and WR.
- Reset (any time, including mid-transaction): all entries invalid, count 0, pointers 0, state IDLE, mem_req dropped immediately; buffered lines are discarded.

## Timing
- Reset values: evict_ready 1, fill_ready 1, fill_rvalid 0, fill_rdata 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0.
- Forwarded fill: accept at cycle N, fill_rvalid at N+1.
- Memory fill: accept at N, mem_req from N+1, fill_rvalid one cycle after mem_ack.
- Drain: mem_req from the cycle after IDLE selects WR; entry freed (evict_ready may rise) the cycle after mem_ack.
- Outputs are registered except evict_ready and fill_ready, which are derived from registered state only (no input-to-output combinational paths).
- mem_addr/mem_we/mem_wdata are stable while mem_req is high.

## Test plan
- Evict line 0x0000010 (data A), no fills -> WR issued, mem_we=1, mem_addr=0x0000010, mem_wdata=A; after mem_ack count=0, evict_ready=1.
- Fill 0x0000010 while A is buffered -> fill_rvalid next cycle with data A, mem_req stays 0.
- Fill 0x0000020 (empty buffer), memory returns B after 3 cycles -> mem_we=0, fill_rvalid one cycle after mem_ack with B.
- Push 4 distinct lines with mem_ack held low -> evict_ready=0 at count=4; one mem_ack -> evict_ready=1 next cycle; drain order matches push order.
- Evict 0x5 data C, then 0x5 data D before drain -> one entry, single drain with D; repeat with D arriving during WR of C -> two writes, C then D.
- Assert rst_n low during RD -> mem_req=0 immediately, count=0, fill_rvalid never pulses.
